// File: rtl/fp_mult_pkg.sv
`default_nettype none
//==============================================================================
// fp_mult_pkg -- shared types, flag indices and helpers for fp_mult_pipe. Rev 1.0
//==============================================================================
package fp_mult_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_class_e;

  localparam int FLAG_W         = 3;
  localparam int FLAG_INVALID   = 2;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 0;

  function automatic int fp_width(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int prod_width(input int man_w);
    return 2 * man_w + 2;
  endfunction

  // Subnormals (exp=0, frac!=0) deliberately classify as zero.
  function automatic fp_class_e classify(input logic exp_zero, input logic exp_ones,
                                         input logic frac_nz);
    if (exp_zero)               return CLS_ZERO;
    else if (exp_ones && frac_nz) return CLS_NAN;
    else if (exp_ones)          return CLS_INF;
    else                        return CLS_NORM;
  endfunction

  // Canonical quiet NaN {0, all-ones, 1, 0...}, returned in a 64-bit container.
  function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < exp_w; i++) r[man_w + i] = 1'b1;
    r[man_w - 1] = 1'b1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_mult_pipe_mant_mult.sv
`default_nettype none
//==============================================================================
// fp_mant_mult -- combinational unsigned significand multiplier. Rev 1.0
//==============================================================================
module fp_mant_mult #(
  parameter int W = 11
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  assign p = (2*W)'(a) * (2*W)'(b);

endmodule
`default_nettype wire

// File: rtl/fp_mult_pipe.sv
`default_nettype none
//==============================================================================
// fp_mult_pipe -- 3-stage FP multiplier, valid/ready; FP_MULT_RNE_EN selects RNE
// rounding, otherwise truncation with saturating overflow. Rev 1.0
//==============================================================================
module fp_mult_pipe
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int BIAS  = 2**(EXP_W-1) - 1
) (
  input  logic                     CLK,
  input  logic                     RESETn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     A,
  input  logic [EXP_W+MAN_W:0]     B,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out,
  output logic [FLAG_W-1:0]        flags
);

  localparam int FP_W   = fp_width(EXP_W, MAN_W);
  localparam int PROD_W = prod_width(MAN_W);
  localparam int XW     = EXP_W + 2;

  localparam logic [EXP_W-1:0]     EXP_ONES = {EXP_W{1'b1}};
  localparam logic signed [XW-1:0] EXP_LIM  = XW'(2**EXP_W - 1);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;
  localparam logic [FP_W-1:0]      QNAN     = FP_W'(canon_nan(EXP_W, MAN_W));

  logic en;
  logic v1, v2, v3;

  assign en        = !v3 || out_ready;
  assign in_ready  = en;
  assign out_valid = v3;

  // ---------------- S1: unpack and classify ----------------
  logic                 sa, sb;
  logic [EXP_W-1:0]     ea, eb;
  logic [MAN_W-1:0]     fa, fb;
  fp_class_e            cls_a_d, cls_b_d;
  logic signed [XW-1:0] exp_sum_d;

  assign {sa, ea, fa} = A;
  assign {sb, eb, fb} = B;
  assign cls_a_d   = classify(ea == '0, ea == EXP_ONES, fa != '0);
  assign cls_b_d   = classify(eb == '0, eb == EXP_ONES, fb != '0);
  assign exp_sum_d = {2'b00, ea} + {2'b00, eb} - XW'(BIAS);

  logic                 s1_sign;
  fp_class_e            s1_cls_a, s1_cls_b;
  logic [MAN_W:0]       s1_sig_a, s1_sig_b;
  logic signed [XW-1:0] s1_exp;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      v1       <= 1'b0;
      s1_sign  <= 1'b0;
      s1_cls_a <= CLS_ZERO;
      s1_cls_b <= CLS_ZERO;
      s1_sig_a <= '0;
      s1_sig_b <= '0;
      s1_exp   <= '0;
    end else if (en) begin
      v1       <= in_valid;
      s1_sign  <= sa ^ sb;
      s1_cls_a <= cls_a_d;
      s1_cls_b <= cls_b_d;
      s1_sig_a <= {1'b1, fa};
      s1_sig_b <= {1'b1, fb};
      s1_exp   <= exp_sum_d;
    end
  end

  // ---------------- S2: multiply ----------------
  logic [PROD_W-1:0] prod_d;

  fp_mant_mult #(.W(MAN_W + 1)) u_mant_mult (
    .a (s1_sig_a),
    .b (s1_sig_b),
    .p (prod_d)
  );

  logic                 s2_sign;
  fp_class_e            s2_cls_a, s2_cls_b;
  logic signed [XW-1:0] s2_exp;
  logic [PROD_W-1:0]    s2_prod;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      v2       <= 1'b0;
      s2_sign  <= 1'b0;
      s2_cls_a <= CLS_ZERO;
      s2_cls_b <= CLS_ZERO;
      s2_exp   <= '0;
      s2_prod  <= '0;
    end else if (en) begin
      v2       <= v1;
      s2_sign  <= s1_sign;
      s2_cls_a <= s1_cls_a;
      s2_cls_b <= s1_cls_b;
      s2_exp   <= s1_exp;
      s2_prod  <= prod_d;
    end
  end

  // ---------------- S3: normalise, round, pack ----------------
  // Left-align so the leading one always sits at PROD_W-1.
  logic [PROD_W-1:0]    norm;
  logic signed [XW-1:0] exp_n, exp_f;
  logic [MAN_W-1:0]     frac_t, frac_r;
  logic                 carry, round_up;
  logic                 unused_lead;

  assign norm        = s2_prod[PROD_W-1] ? s2_prod : {s2_prod[PROD_W-2:0], 1'b0};
  assign exp_n       = s2_prod[PROD_W-1] ? s2_exp + XW'(1) : s2_exp;
  assign frac_t      = norm[PROD_W-2 -: MAN_W];
  assign unused_lead = norm[PROD_W-1];

`ifdef FP_MULT_RNE_EN
  logic guard, sticky;
  assign guard    = norm[PROD_W-2-MAN_W];
  assign sticky   = |norm[PROD_W-3-MAN_W:0];
  assign round_up = guard & (sticky | frac_t[0]);
`else
  logic unused_tail;
  assign unused_tail = |norm[PROD_W-2-MAN_W:0];
  assign round_up    = 1'b0;
`endif

  assign {carry, frac_r} = {1'b0, frac_t} + {{MAN_W{1'b0}}, round_up};
  assign exp_f           = carry ? exp_n + XW'(1) : exp_n;

  logic [FP_W-1:0]   res;
  logic [FLAG_W-1:0] flg;
  logic nan_any, inf_a, inf_b, zero_a, zero_b;

  assign nan_any = (s2_cls_a == CLS_NAN) || (s2_cls_b == CLS_NAN);
  assign inf_a   = (s2_cls_a == CLS_INF);
  assign inf_b   = (s2_cls_b == CLS_INF);
  assign zero_a  = (s2_cls_a == CLS_ZERO);
  assign zero_b  = (s2_cls_b == CLS_ZERO);

  always_comb begin
    res = {s2_sign, exp_f[EXP_W-1:0], frac_r};
    flg = '0;
    if (nan_any || (inf_a && zero_b) || (zero_a && inf_b)) begin
      res               = QNAN;
      flg[FLAG_INVALID] = 1'b1;
    end else if (inf_a || inf_b) begin
      res = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
    end else if (zero_a || zero_b) begin
      res = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
    end else if (exp_f >= EXP_LIM) begin
      flg[FLAG_OVERFLOW] = 1'b1;
`ifdef FP_MULT_RNE_EN
      res = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
`else
      res = {s2_sign, EXP_ONES - EXP_W'(1), {MAN_W{1'b1}}};
`endif
    end else if (exp_f <= EXP_ZERO) begin
      flg[FLAG_UNDERFLOW] = 1'b1;
      res = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      v3    <= 1'b0;
      out   <= '0;
      flags <= '0;
    end else if (en) begin
      v3 <= v2;
      if (v2) begin
        out   <= res;
        flags <= flg;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_mult_pipe.sv
`default_nettype none
//==============================================================================
// tb_fp_mult_pipe -- vector table, hand sequences and random stimulus against a
// real-arithmetic reference model (honours FP_MULT_RNE_EN). Rev 1.0
//==============================================================================
module tb_fp_mult_pipe;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0, B = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out;
  logic [2:0]  flags;

  always #5 CLK = ~CLK;

  fp_mult_pipe dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flags     (flags)
  );

  typedef struct packed {
    logic [15:0] res;
    logic [2:0]  flg;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    exp_t        e;
  } vec_t;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  exp_t cur_exp;
  exp_t mon_e;
  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: value arithmetic in reals, rounding decided on the remainder.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t r;
    int   ea, eb, fa, fb, e, ip;
    bit   s, za, zb, ia, ib, na, nb;
    real  x, f;
`ifdef FP_MULT_RNE_EN
    real  rem;
`endif
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    fa = int'(a[9:0]);   fb = int'(b[9:0]);
    s  = a[15] ^ b[15];
    za = (ea == 0); zb = (eb == 0);
    ia = (ea == 31) && (fa == 0); ib = (eb == 31) && (fb == 0);
    na = (ea == 31) && (fa != 0); nb = (eb == 31) && (fb != 0);
    r.flg = 3'b000;
    if (na || nb || (ia && zb) || (za && ib)) begin
      r.res = 16'h7E00; r.flg = 3'b100; return r;
    end
    if (ia || ib) begin r.res = {s, 5'h1F, 10'h000}; return r; end
    if (za || zb) begin r.res = {s, 15'h0000}; return r; end
    x = real'((1024 + fa) * (1024 + fb)) / 1048576.0;
    e = ea + eb - 15;
    if (x >= 2.0) begin x = x / 2.0; e++; end
    f  = (x - 1.0) * 1024.0;
    ip = int'($floor(f));
`ifdef FP_MULT_RNE_EN
    rem = f - real'(ip);
    if (rem > 0.5 || (rem == 0.5 && (ip % 2) == 1)) ip++;
`endif
    if (ip == 1024) begin ip = 0; e++; end
    if (e >= 31) begin
      r.flg = 3'b010;
`ifdef FP_MULT_RNE_EN
      r.res = {s, 5'h1F, 10'h000};
`else
      r.res = {s, 5'h1E, 10'h3FF};
`endif
    end else if (e <= 0) begin
      r.flg = 3'b001;
      r.res = {s, 15'h0000};
    end else begin
      r.res = {s, 5'(e), 10'(ip)};
    end
    return r;
  endfunction

  // Scoreboard: capture on acceptance, compare on transfer, police stalls.
  logic        stalled = 1'b0;
  logic [18:0] held = '0;
  always @(negedge CLK) begin
    if (RESETn) begin
      if (in_valid && in_ready) exp_q.push_back(cur_exp);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", {out, flags}, 32'h0);
        end else begin
          mon_e = exp_q.pop_front();
          check("result", {13'h0, out, flags}, {13'h0, mon_e.res, mon_e.flg});
        end
      end
      if (out_valid && !out_ready) begin
        check("in_ready_during_stall", in_ready, 0);
        if (stalled) check("out_hold", {out, flags}, held);
        held    = {out, flags};
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the acceptance edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input exp_t e);
    int t;
    bit ok;
    A = a; B = b; cur_exp = e; in_valid = 1'b1;
    t = 0;
    do begin
      @(negedge CLK);
      ok = in_ready;
      if (!ok) t++;
    end while (!ok && t < 60);
    if (!ok) check("send_timeout", 0, 1);
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    out_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge CLK); #1; t++;
    end
    check("drain_remaining", exp_q.size(), 0);
  endtask

  function automatic logic [15:0] rand_op();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 11))
      0: v[14:10] = 5'h00;
      1: v[14:10] = 5'h1F;
      2: begin v[14:10] = 5'h1F; v[9:0] = 10'h000; end
      3: v[14:10] = 5'(25 + $urandom_range(0, 5));
      4: v[14:10] = 5'($urandom_range(1, 5));
      default: v[14:10] = 5'($urandom_range(10, 20));
    endcase
    return v;
  endfunction

  task automatic set_vec(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] res, input logic [2:0] flg);
    tbl[i].a     = a;
    tbl[i].b     = b;
    tbl[i].e.res = res;
    tbl[i].e.flg = flg;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1);
  end

  initial begin
    int  lat;
    bit  done;
    int  seen_valid;

    set_vec(0,  16'h3E00, 16'h3E00, 16'h4080, 3'b000);
`ifdef FP_MULT_RNE_EN
    set_vec(1,  16'h3C01, 16'h3E00, 16'h3E02, 3'b000);
    set_vec(3,  16'h7BFF, 16'h4000, 16'h7C00, 3'b010);
`else
    set_vec(1,  16'h3C01, 16'h3E00, 16'h3E01, 3'b000);
    set_vec(3,  16'h7BFF, 16'h4000, 16'h7BFF, 3'b010);
`endif
    set_vec(2,  16'h3C01, 16'h3C01, 16'h3C02, 3'b000);
    set_vec(4,  16'h7C00, 16'h0000, 16'h7E00, 3'b100);
    set_vec(5,  16'hFC00, 16'h3C00, 16'hFC00, 3'b000);
    set_vec(6,  16'h0400, 16'h0400, 16'h0000, 3'b001);
    set_vec(7,  16'h8000, 16'h3C00, 16'h8000, 3'b000);
    set_vec(8,  16'h7C01, 16'h3C00, 16'h7E00, 3'b100);
    set_vec(9,  16'h0001, 16'h3C00, 16'h0000, 3'b000);
    set_vec(10, 16'hC000, 16'h3C00, 16'hC000, 3'b000);
    set_vec(11, 16'h7C00, 16'h7C00, 16'h7C00, 3'b000);

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out", out, 0);
    check("reset_flags", flags, 0);
    check("reset_in_ready", in_ready, 1);
    RESETn = 1'b1;
    @(posedge CLK); #1;

    // Latency of a single product into an empty pipe
    send(16'h3E00, 16'h3E00, tbl[0].e);
    lat = 0;
    do begin @(negedge CLK); lat++; end while (!out_valid && lat < 10);
    check("latency", lat, 3);
    drain();

    // Table vectors, back to back
    for (int i = 0; i < 12; i++) send(tbl[i].a, tbl[i].b, tbl[i].e);
    drain();

    // Backpressure: six pairs with out_ready low for five cycles
    @(posedge CLK); #1;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(tbl[i].a, tbl[i + 6].b, model(tbl[i].a, tbl[i + 6].b));
      end
      begin
        repeat (5) @(posedge CLK);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset while results are in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(16'h3E00, 16'h3E00, tbl[0].e);
    @(negedge CLK);
    check("pre_reset_out_valid", out_valid, 1);
    #1 RESETn = 1'b0;
    #1;
    check("async_reset_out_valid", out_valid, 0);
    check("async_reset_out", out, 0);
    exp_q.delete();
    @(posedge CLK); #1;
    RESETn    = 1'b1;
    out_ready = 1'b1;
    check("post_reset_in_ready", in_ready, 1);
    seen_valid = 0;
    repeat (8) begin @(negedge CLK); if (out_valid) seen_valid++; end
    check("no_stale_after_reset", seen_valid, 0);
    @(posedge CLK); #1;

    // Random operands with random backpressure and input gaps
    done = 1'b0;
    fork
      begin
        logic [15:0] ra, rb;
        for (int i = 0; i < 300; i++) begin
          ra = rand_op();
          rb = rand_op();
          send(ra, rb, model(ra, rb));
          if ($urandom_range(0, 3) == 0) begin @(posedge CLK); #1; end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge CLK); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
